// File: rtl/cache_stats_unit.sv
// ---------------------------------------------------------------------------
// cache_stats_unit
//
// Sits downstream of the cache model and keeps statistics on it. Each
// completed trace command arrives as a one-cycle acc_valid beat and bumps
// saturating read/write/hit/miss counters. A PRINT beat snapshots the hit and
// miss counts. A multi-cycle restoring divider then computes the hit ratio in
// per-mille, and the result is presented for one cycle on ratio_valid.
//
// Optional feature (compile-time macro STATS_SNOOP_EN):
//   adds input snoop_result and outputs num_snoops / num_hitm. When the macro
//   is undefined these ports do not exist and snoop commands are ignored.
//
// Ports
//   clk          in   1      system clock, rising edge
//   reset_n      in   1      synchronous active-low reset
//   acc_valid    in   1      access-result beat (always accepted)
//   acc_cmd      in   4      command code: 0 READ, 1 WRITE, 2 L1_READ,
//                            3..6 SNOOP, 8 CLR, 9 PRINT
//   acc_hit      in   1      access hit
//   acc_miss     in   1      access miss
//   snoop_result in   2      snoop response (STATS_SNOOP_EN only)
//   num_reads    out  CNT_W  READ + L1_READ beats
//   num_writes   out  CNT_W  WRITE beats
//   num_hits     out  CNT_W  hits on cmd 0/1/2
//   num_misses   out  CNT_W  misses on cmd 0/1/2
//   num_snoops   out  CNT_W  cmd 3..6 beats (STATS_SNOOP_EN only)
//   num_hitm     out  CNT_W  snoop beats with HITM (STATS_SNOOP_EN only)
//   ratio_pm     out  10     hits*1000/(hits+misses), truncated
//   ratio_valid  out  1      one-cycle result pulse
//   div0         out  1      last ratio had a zero denominator
//   busy         out  1      divide in progress; PRINT ignored
//   sat_flag     out  1      sticky: some counter saturated
//   err_flag     out  1      sticky: hit and miss both set on a counted beat
//
// FSM states
//   state  | meaning
//   IDLE   | waiting for PRINT
//   LOAD   | snapshot held, check for zero denominator, init divider
//   DIV    | one restoring quotient bit per cycle, CNT_W+10 cycles
//   DONE   | result registered, ratio_valid high
// ---------------------------------------------------------------------------
module cache_stats_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             acc_valid,
    input  logic [3:0]       acc_cmd,
    input  logic             acc_hit,
    input  logic             acc_miss,
`ifdef STATS_SNOOP_EN
    input  logic [1:0]       snoop_result,
`endif
    output logic [CNT_W-1:0] num_reads,
    output logic [CNT_W-1:0] num_writes,
    output logic [CNT_W-1:0] num_hits,
    output logic [CNT_W-1:0] num_misses,
`ifdef STATS_SNOOP_EN
    output logic [CNT_W-1:0] num_snoops,
    output logic [CNT_W-1:0] num_hitm,
`endif
    output logic [9:0]       ratio_pm,
    output logic             ratio_valid,
    output logic             div0,
    output logic             busy,
    output logic             sat_flag,
    output logic             err_flag
);

    localparam int N_W  = CNT_W + 10;
    localparam int D_W  = CNT_W + 1;
    localparam int BC_W = $clog2(N_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [CNT_W-1:0]   r_num_reads;
    logic [CNT_W-1:0]   r_num_writes;
    logic [CNT_W-1:0]   r_num_hits;
    logic [CNT_W-1:0]   r_num_misses;
    logic               r_sat_flag;
    logic               r_err_flag;

    logic [N_W-1:0]     r_dq;       // dividend, shifted out MSB-first; quotient shifts in at LSB
    logic [D_W-1:0]     r_den;
    logic [D_W-1:0]     r_rem;
    logic [BC_W-1:0]    r_bit_cnt;
    logic [9:0]         r_ratio_pm;
    logic               r_div0;

    // Beat decode
    logic w_beat_rd, w_beat_wr, w_beat_acc, w_both;
    logic w_inc_hit, w_inc_miss, w_clr, w_print;
    logic w_sat_base, w_sat_snp, w_sat_event;

    assign w_beat_rd  = acc_valid && ((acc_cmd == 4'd0) || (acc_cmd == 4'd2));
    assign w_beat_wr  = acc_valid && (acc_cmd == 4'd1);
    assign w_beat_acc = w_beat_rd || w_beat_wr;
    assign w_both     = acc_hit && acc_miss;
    assign w_inc_hit  = w_beat_acc && acc_hit && !acc_miss;
    assign w_inc_miss = w_beat_acc && acc_miss && !acc_hit;
    assign w_clr      = acc_valid && (acc_cmd == 4'd8);
    assign w_print    = acc_valid && (acc_cmd == 4'd9);

    // An increment arriving at an all-ones counter is the would-wrap event.
    assign w_sat_base = (w_beat_rd  && (&r_num_reads))  ||
                        (w_beat_wr  && (&r_num_writes)) ||
                        (w_inc_hit  && (&r_num_hits))   ||
                        (w_inc_miss && (&r_num_misses));
    assign w_sat_event = w_sat_base || w_sat_snp;

    always_ff @(posedge clk) begin
        if (!reset_n || w_clr) begin
            r_num_reads  <= '0;
            r_num_writes <= '0;
            r_num_hits   <= '0;
            r_num_misses <= '0;
            r_sat_flag   <= 1'b0;
            r_err_flag   <= 1'b0;
        end else begin
            if (w_beat_rd && !(&r_num_reads))
                r_num_reads <= r_num_reads + CNT_W'(1);
            if (w_beat_wr && !(&r_num_writes))
                r_num_writes <= r_num_writes + CNT_W'(1);
            if (w_inc_hit && !(&r_num_hits))
                r_num_hits <= r_num_hits + CNT_W'(1);
            if (w_inc_miss && !(&r_num_misses))
                r_num_misses <= r_num_misses + CNT_W'(1);
            if (w_sat_event)
                r_sat_flag <= 1'b1;
            if (w_beat_acc && w_both)
                r_err_flag <= 1'b1;
        end
    end

`ifdef STATS_SNOOP_EN
    logic [CNT_W-1:0] r_num_snoops;
    logic [CNT_W-1:0] r_num_hitm;
    logic             w_beat_snp;
    logic             w_beat_hitm;

    assign w_beat_snp  = acc_valid && (acc_cmd >= 4'd3) && (acc_cmd <= 4'd6);
    assign w_beat_hitm = w_beat_snp && (snoop_result == 2'd1);
    assign w_sat_snp   = (w_beat_snp  && (&r_num_snoops)) ||
                         (w_beat_hitm && (&r_num_hitm));

    always_ff @(posedge clk) begin
        if (!reset_n || w_clr) begin
            r_num_snoops <= '0;
            r_num_hitm   <= '0;
        end else begin
            if (w_beat_snp && !(&r_num_snoops))
                r_num_snoops <= r_num_snoops + CNT_W'(1);
            if (w_beat_hitm && !(&r_num_hitm))
                r_num_hitm <= r_num_hitm + CNT_W'(1);
        end
    end

    assign num_snoops = r_num_snoops;
    assign num_hitm   = r_num_hitm;
`else
    assign w_sat_snp = 1'b0;
`endif

    // Divider datapath
    logic [N_W-1:0] w_num_prod;
    logic [D_W-1:0] w_den_sum;
    logic [D_W:0]   w_rem_sh;
    logic [D_W:0]   w_rem_sub;
    logic           w_ge;
    logic [D_W-1:0] w_rem_next;
    logic [N_W-1:0] w_q_next;
    logic           w_unused_sub;

    assign w_num_prod = N_W'(r_num_hits) * N_W'(1000);
    assign w_den_sum  = D_W'(r_num_hits) + D_W'(r_num_misses);

    assign w_rem_sh   = {r_rem, r_dq[N_W-1]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_den});
    assign w_rem_sub  = w_rem_sh - {1'b0, r_den};
    // Remainder always stays below the denominator, so D_W bits suffice.
    assign w_rem_next = w_ge ? w_rem_sub[D_W-1:0] : w_rem_sh[D_W-1:0];
    assign w_q_next   = {r_dq[N_W-2:0], w_ge};
    assign w_unused_sub = w_rem_sub[D_W];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_dq       <= '0;
            r_den      <= '0;
            r_rem      <= '0;
            r_bit_cnt  <= '0;
            r_ratio_pm <= '0;
            r_div0     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_print) begin
                        r_dq  <= w_num_prod;
                        r_den <= w_den_sum;
                    end
                end
                S_LOAD: begin
                    r_rem     <= '0;
                    r_bit_cnt <= BC_W'(N_W - 1);
                end
                S_DIV: begin
                    r_rem     <= w_rem_next;
                    r_dq      <= w_q_next;
                    r_bit_cnt <= r_bit_cnt - BC_W'(1);
                end
                default: ;
            endcase

            // Result lands on the edge that enters DONE, so it is valid
            // in the same cycle as the ratio_valid pulse.
            if (w_clr) begin
                r_ratio_pm <= '0;
                r_div0     <= 1'b0;
            end else if ((r_state == S_LOAD) && (r_den == '0)) begin
                r_ratio_pm <= '0;
                r_div0     <= 1'b1;
            end else if ((r_state == S_DIV) && (r_bit_cnt == '0)) begin
                r_ratio_pm <= w_q_next[9:0];
                r_div0     <= 1'b0;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_print) w_state_nxt = S_LOAD;
            S_LOAD: w_state_nxt = (r_den == '0) ? S_DONE : S_DIV;
            S_DIV:  if (r_bit_cnt == '0) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_clr)
            w_state_nxt = S_IDLE;
    end

    // FSM: outputs
    always_comb begin
        busy        = 1'b0;
        ratio_valid = 1'b0;
        case (r_state)
            S_LOAD, S_DIV: busy = 1'b1;
            S_DONE: begin
                busy        = 1'b1;
                ratio_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign num_reads  = r_num_reads;
    assign num_writes = r_num_writes;
    assign num_hits   = r_num_hits;
    assign num_misses = r_num_misses;
    assign ratio_pm   = r_ratio_pm;
    assign div0       = r_div0;
    assign sat_flag   = r_sat_flag;
    assign err_flag   = r_err_flag;

endmodule

// File: tb/tb_cache_stats_unit.sv
// ---------------------------------------------------------------------------
// tb_cache_stats_unit
//
// Directed bench for cache_stats_unit with CNT_W = 16. Inputs are driven and
// outputs sampled 1 time unit after each rising edge. Latency values count
// cycles after the PRINT edge: the state seen just after that edge is 1.
// ---------------------------------------------------------------------------
module tb_cache_stats_unit;

    localparam int CNT_W = 16;

    logic             clk;
    logic             reset_n;
    logic             acc_valid;
    logic [3:0]       acc_cmd;
    logic             acc_hit;
    logic             acc_miss;
    logic [CNT_W-1:0] num_reads;
    logic [CNT_W-1:0] num_writes;
    logic [CNT_W-1:0] num_hits;
    logic [CNT_W-1:0] num_misses;
    logic [9:0]       ratio_pm;
    logic             ratio_valid;
    logic             div0;
    logic             busy;
    logic             sat_flag;
    logic             err_flag;
`ifdef STATS_SNOOP_EN
    logic [1:0]       snoop_result;
    logic [CNT_W-1:0] num_snoops;
    logic [CNT_W-1:0] num_hitm;
`endif

    int n_vec = 0;
    int n_err = 0;
    int lat;
    int pulses;

    cache_stats_unit #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .acc_valid   (acc_valid),
        .acc_cmd     (acc_cmd),
        .acc_hit     (acc_hit),
        .acc_miss    (acc_miss),
`ifdef STATS_SNOOP_EN
        .snoop_result(snoop_result),
        .num_snoops  (num_snoops),
        .num_hitm    (num_hitm),
`endif
        .num_reads   (num_reads),
        .num_writes  (num_writes),
        .num_hits    (num_hits),
        .num_misses  (num_misses),
        .ratio_pm    (ratio_pm),
        .ratio_valid (ratio_valid),
        .div0        (div0),
        .busy        (busy),
        .sat_flag    (sat_flag),
        .err_flag    (err_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input logic [3:0] cmd, input logic hit, input logic miss);
        acc_valid = 1'b1;
        acc_cmd   = cmd;
        acc_hit   = hit;
        acc_miss  = miss;
        @(posedge clk);
        #1;
        acc_valid = 1'b0;
        acc_cmd   = 4'd0;
        acc_hit   = 1'b0;
        acc_miss  = 1'b0;
    endtask

    // Bounded wait for ratio_valid; lat starts at the cycle index already reached.
    task automatic wait_ratio(input int start, output int l);
        l = start;
        while ((ratio_valid !== 1'b1) && (l < 60)) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic count_pulses(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (ratio_valid === 1'b1) c++;
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        acc_valid = 1'b0;
        acc_cmd   = 4'd0;
        acc_hit   = 1'b0;
        acc_miss  = 1'b0;
`ifdef STATS_SNOOP_EN
        snoop_result = 2'd0;
`endif

        // Reset state
        idle(3);
        chk("rst_busy",  busy, 0);
        chk("rst_valid", ratio_valid, 0);
        chk("rst_reads", num_reads, 0);

        // Test 1: idle after reset
        reset_n = 1'b1;
        idle(5);
        chk("idle_reads",  num_reads, 0);
        chk("idle_writes", num_writes, 0);
        chk("idle_hits",   num_hits, 0);
        chk("idle_misses", num_misses, 0);
        chk("idle_ratio",  ratio_pm, 0);
        chk("idle_valid",  ratio_valid, 0);
        chk("idle_div0",   div0, 0);
        chk("idle_busy",   busy, 0);
        chk("idle_sat",    sat_flag, 0);
        chk("idle_err",    err_flag, 0);

        // Test 2: 3 read hits, 1 write miss -> 3000/4 = 750
        beat(4'd0, 1'b1, 1'b0);
        beat(4'd0, 1'b1, 1'b0);
        beat(4'd0, 1'b1, 1'b0);
        beat(4'd1, 1'b0, 1'b1);
        chk("t2_reads",  num_reads, 3);
        chk("t2_writes", num_writes, 1);
        chk("t2_hits",   num_hits, 3);
        chk("t2_misses", num_misses, 1);
        beat(4'd9, 1'b0, 1'b0);
        chk("t2_busy", busy, 1);
        wait_ratio(1, lat);
        chk("t2_latency", lat, 28);
        chk("t2_ratio",   ratio_pm, 750);
        chk("t2_div0",    div0, 0);
        idle(1);
        chk("t2_pulse_end", ratio_valid, 0);
        chk("t2_busy_end",  busy, 0);
        chk("t2_ratio_hold", ratio_pm, 750);

        // Test 3: CLR then PRINT with zero denominator
        beat(4'd8, 1'b0, 1'b0);
        chk("t3_clr_reads", num_reads, 0);
        chk("t3_clr_ratio", ratio_pm, 0);
        beat(4'd9, 1'b0, 1'b0);
        wait_ratio(1, lat);
        chk("t3_latency", lat, 2);
        chk("t3_ratio",   ratio_pm, 0);
        chk("t3_div0",    div0, 1);

        // Test 6: hit&miss on READ, ignored codes, then build hits=2 misses=1
        beat(4'd0, 1'b1, 1'b1);
        chk("t6_reads",  num_reads, 1);
        chk("t6_hits",   num_hits, 0);
        chk("t6_misses", num_misses, 0);
        chk("t6_err",    err_flag, 1);
        beat(4'd5, 1'b1, 1'b0);
        beat(4'd7, 1'b1, 1'b0);
        beat(4'd12, 1'b0, 1'b1);
        chk("ign_reads",  num_reads, 1);
        chk("ign_writes", num_writes, 0);
        chk("ign_hits",   num_hits, 0);
        chk("ign_misses", num_misses, 0);
        beat(4'd2, 1'b0, 1'b1);
        beat(4'd2, 1'b1, 1'b0);
        beat(4'd2, 1'b1, 1'b0);
        chk("l1_reads", num_reads, 4);
        chk("l1_hits",  num_hits, 2);

        // Concurrency: count during divide, second PRINT dropped; 2000/3 = 666
        beat(4'd9, 1'b0, 1'b0);
        beat(4'd0, 1'b0, 1'b1);
        beat(4'd9, 1'b0, 1'b0);
        wait_ratio(3, lat);
        chk("cc_latency", lat, 28);
        chk("cc_ratio",   ratio_pm, 666);
        chk("cc_misses",  num_misses, 2);
        chk("cc_reads",   num_reads, 5);
        count_pulses(40, pulses);
        chk("cc_no_extra_pulse", pulses, 0);

        // Test 5: PRINT, PRINT while busy, CLR 10 cycles after the first PRINT
        beat(4'd9, 1'b0, 1'b0);
        idle(3);
        beat(4'd9, 1'b0, 1'b0);
        idle(5);
        chk("t5_busy_pre", busy, 1);
        beat(4'd8, 1'b0, 1'b0);
        chk("t5_busy",   busy, 0);
        chk("t5_reads",  num_reads, 0);
        chk("t5_misses", num_misses, 0);
        chk("t5_err",    err_flag, 0);
        chk("t5_ratio",  ratio_pm, 0);
        chk("t5_div0",   div0, 0);
        count_pulses(40, pulses);
        chk("t5_no_pulse", pulses, 0);

`ifdef STATS_SNOOP_EN
        snoop_result = 2'd1;
        beat(4'd4, 1'b0, 1'b0);
        chk("snp_snoops", num_snoops, 1);
        chk("snp_hitm",   num_hitm, 1);
        snoop_result = 2'd2;
        beat(4'd6, 1'b0, 1'b0);
        snoop_result = 2'd0;
        chk("snp_snoops2", num_snoops, 2);
        chk("snp_hitm2",   num_hitm, 1);
        beat(4'd8, 1'b0, 1'b0);
        chk("snp_clr", num_snoops, 0);
`endif

        // Test 4: hits to 16'hFFFE, then 2 more hits
        acc_valid = 1'b1;
        acc_cmd   = 4'd0;
        acc_hit   = 1'b1;
        acc_miss  = 1'b0;
        repeat (65534) @(posedge clk);
        #1;
        acc_valid = 1'b0;
        acc_hit   = 1'b0;
        chk("t4_hits_fffe", num_hits, 32'hFFFE);
        chk("t4_sat_pre",   sat_flag, 0);
        beat(4'd0, 1'b1, 1'b0);
        chk("t4_hits_ffff", num_hits, 32'hFFFF);
        chk("t4_sat_edge",  sat_flag, 0);
        beat(4'd0, 1'b1, 1'b0);
        chk("t4_hits_sat",  num_hits, 32'hFFFF);
        chk("t4_reads_sat", num_reads, 32'hFFFF);
        chk("t4_sat",       sat_flag, 1);
        beat(4'd9, 1'b0, 1'b0);
        wait_ratio(1, lat);
        chk("t4_latency", lat, 28);
        chk("t4_ratio",   ratio_pm, 1000);
        chk("t4_div0",    div0, 0);

        // Reset mid-divide
        idle(2);
        beat(4'd9, 1'b0, 1'b0);
        idle(5);
        reset_n = 1'b0;
        idle(1);
        chk("rmd_busy",  busy, 0);
        chk("rmd_hits",  num_hits, 0);
        chk("rmd_sat",   sat_flag, 0);
        chk("rmd_ratio", ratio_pm, 0);
        reset_n = 1'b1;
        count_pulses(40, pulses);
        chk("rmd_no_pulse", pulses, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
